mem_stage_ctrl: RTL

- Parametrised successor to the single-cycle memory stage, for the pipelined core.
- Sits between the EX/MEM register and the writeback stage.
- Resolves branch and jump target selection.
- Drives a variable-latency data memory through a request/acknowledge handshake, stalling upstream while an access is outstanding.
- Registers all results into the MEM/WB boundary.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/pc_redirect.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the pipelined memory stage.
package mem_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    // IDLE accepts a new EX/MEM instruction; WAIT holds an outstanding memory access.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pc_redirect.sv
// Next-PC selection for the retiring instruction: jump target, branch target or fall-through.
module pc_redirect
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] off,
    input  logic [ADDR_W-1:0] target,
    input  logic              brch,
    input  logic              jmp,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] brch_pc;

    // The branch target wraps modulo 2^ADDR_W; the carry out is intentionally dropped.
    assign brch_pc = pc + off;

    always_comb begin
        next_pc = pc;
        if (jmp) begin
            next_pc = target;
        end else if (brch) begin
            next_pc = brch_pc;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage of the pipelined core: next-PC resolution, request/ack data-memory
// handshake with upstream stall, and the MEM/WB boundary registers.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] jmp_off,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] st_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              brch_cnd,
    input  logic              alu_jmp,
    input  logic              regsrc_in,
    input  logic              setrd_in,
    input  logic              createdump,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_dump,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_alu,
    output logic [ADDR_W-1:0] wb_pc,
    output logic              wb_regsrc,
    output logic              wb_setrd,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              align_err
);

    state_t            state;
    state_t            state_nxt;
    logic              mem_op;
    logic              mis;
    logic              acc_ok;
    logic              retire;
    logic              capture;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic              hold_we;

    assign mem_op  = ex_valid & (mem_rd | mem_wr);
    // Simultaneous load and store is malformed and is suppressed like a misaligned access.
    assign mis     = mem_op & ((ALIGN_CHK & alu_res[0]) | (mem_rd & mem_wr));
    assign acc_ok  = mem_op & ~mis;
    assign jmp_tgt = ADDR_W'(alu_res);

    assign mem_dump = createdump & ex_valid;

    pc_redirect #(
        .ADDR_W(ADDR_W)
    ) u_pc_redirect (
        .pc     (pc_in),
        .off    (jmp_off),
        .target (jmp_tgt),
        .brch   (brch_cnd),
        .jmp    (alu_jmp),
        .next_pc(next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = jmp_tgt;
        mem_wdata = st_data;
        stall     = 1'b0;
        retire    = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                if (acc_ok) begin
                    mem_req = 1'b1;
                    mem_we  = mem_wr;
                    capture = 1'b1;
                    if (mem_ack) begin
                        retire = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                    end
                end else if (ex_valid) begin
                    retire = 1'b1;
                end
            end
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = hold_we;
                mem_addr  = hold_addr;
                mem_wdata = hold_wdata;
                if (mem_ack) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reset silences the handshake immediately, even with a memory op still presented.
        if (!rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            stall   = 1'b0;
            retire  = 1'b0;
            capture = 1'b0;
        end
    end

    // NOTE: the holding registers carry no reset; they are only read in WAIT, which is
    // entered solely through a cycle that loads them.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_addr  <= jmp_tgt;
            hold_wdata <= st_data;
            hold_we    <= mem_wr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid       <= 1'b0;
            wb_rdata       <= '0;
            wb_alu         <= '0;
            wb_pc          <= '0;
            wb_regsrc      <= 1'b0;
            wb_setrd       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            align_err      <= 1'b0;
        end else begin
            wb_valid       <= retire;
            align_err      <= retire & mis;
            redirect_valid <= retire & (brch_cnd | alu_jmp);
            if (retire) begin
                wb_rdata    <= (mem_rd & ~mis) ? mem_rdata : '0;
                wb_alu      <= alu_res;
                wb_pc       <= pc_in;
                wb_regsrc   <= regsrc_in;
                wb_setrd    <= setrd_in;
                redirect_pc <= next_pc;
            end
        end
    end

endmodule
